// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencer: FSM encoding, default taps/seed
// and the Fibonacci step function used by the core and the period checker.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam int         LFSR_MAX_W     = 32;
  localparam int         LFSR_DEF_WIDTH = 3;
  localparam int         LFSR_DEF_CNT_W = 8;
  localparam logic [2:0] LFSR_DEF_TAPS  = 3'b110;
  localparam logic [2:0] LFSR_DEF_SEED  = 3'b001;

  // Shift left, feed back the parity of the tapped bits into bit 0, and keep
  // only the low w bits so callers can zero-extend any width up to LFSR_MAX_W.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps,
    input int                    w
  );
    logic [LFSR_MAX_W-1:0] mask;
    logic [LFSR_MAX_W-1:0] nxt;
    mask = (w >= LFSR_MAX_W) ? '1 : ((LFSR_MAX_W'(1) << w) - LFSR_MAX_W'(1));
    nxt  = {s[LFSR_MAX_W-2:0], ^(s & taps)} & mask;
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register: load / step / hold, with automatic recovery from the
// all-zero lock-up state back to DEFAULT_SEED.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = LFSR_DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS         = LFSR_DEF_TAPS,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR_DEF_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state,
  output logic             zero
);

  logic [LFSR_MAX_W-1:0] nxt_full;
  logic [WIDTH-1:0]      step_val;

  assign zero     = (state == '0);
  assign nxt_full = lfsr_next(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS), WIDTH);
  assign step_val = nxt_full[WIDTH-1:0];

  generate
    if (WIDTH < LFSR_MAX_W) begin : g_unused
      logic unused_hi;
      assign unused_hi = |nxt_full[LFSR_MAX_W-1:WIDTH];
    end
  endgenerate

  // State register: recovery beats load, load beats step; a zero seed is
  // replaced by DEFAULT_SEED so the register can never be loaded into lock-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DEFAULT_SEED;
    end else if (zero) begin
      state <= DEFAULT_SEED;
    end else if (load) begin
      state <= (load_val == '0) ? DEFAULT_SEED : load_val;
    end else if (step) begin
      state <= step_val;
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Burst sequencer around lfsr_core: seed loading, req/ack burst handshake,
// burst counter with abort, sticky lock-up flag.
// Optional feature macro: LFSR_SEQ_CTRL_PERIOD_CHECK_EN adds a period checker
// driving period_err; without it period_err is tied low.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = LFSR_DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS         = LFSR_DEF_TAPS,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR_DEF_SEED,
  parameter int               CNT_W        = LFSR_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_vld,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             ack,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic             done,
  output logic             lockup_err,
  output logic             period_err
);

  seq_state_t       st, st_nxt;
  logic [CNT_W-1:0] cnt;
  logic             core_load;
  logic             core_zero;

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk      (clk),
    .rst      (rst_n),
    .load     (core_load),
    .load_val (seed),
    .step     (q_vld),
    .state    (q),
    .zero     (core_zero)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst_n) st <= ST_IDLE;
    else       st <= st_nxt;
  end

  // FSM next state: seed beats req in IDLE; abort or last word ends a burst
  always_comb begin
    st_nxt = st;
    unique case (st)
      ST_IDLE: if (!seed_vld && req) st_nxt = (len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (abort || (q_vld && cnt == CNT_W'(1))) st_nxt = ST_DONE;
      ST_DONE: st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: a word is emitted only when not aborting and not recovering
  always_comb begin
    ack       = (st == ST_IDLE) && req && !seed_vld;
    core_load = (st == ST_IDLE) && seed_vld;
    busy      = (st == ST_RUN);
    q_vld     = (st == ST_RUN) && !abort && !core_zero;
    done      = (st == ST_DONE);
  end

  // Burst counter: loaded on ack, decremented per emitted word
  always_ff @(posedge clk) begin
    if (rst_n)      cnt <= '0;
    else if (ack)   cnt <= len;
    else if (q_vld) cnt <= cnt - CNT_W'(1);
  end

  // Sticky lock-up flag: zero state observed or zero seed requested
  always_ff @(posedge clk) begin
    if (rst_n)
      lockup_err <= 1'b0;
    else if (core_zero || (core_load && seed == '0))
      lockup_err <= 1'b1;
  end

`ifdef LFSR_SEQ_CTRL_PERIOD_CHECK_EN
  localparam logic [WIDTH:0] PERIOD = {1'b0, {WIDTH{1'b1}}};

  logic [WIDTH-1:0]      ref_seed;
  logic [WIDTH:0]        per_cnt;
  logic [WIDTH:0]        per_inc;
  logic [LFSR_MAX_W-1:0] chk_full;
  logic [WIDTH-1:0]      chk_nxt;

  assign per_inc  = per_cnt + 1'b1;
  assign chk_full = lfsr_next(LFSR_MAX_W'(q), LFSR_MAX_W'(TAPS), WIDTH);
  assign chk_nxt  = chk_full[WIDTH-1:0];

  generate
    if (WIDTH < LFSR_MAX_W) begin : g_chk_unused
      logic unused_chk_hi;
      assign unused_chk_hi = |chk_full[LFSR_MAX_W-1:WIDTH];
    end
  endgenerate

  // Period checker: count steps since the last load and verify the count
  // each time the sequence returns to the loaded value
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ref_seed   <= DEFAULT_SEED;
      per_cnt    <= '0;
      period_err <= 1'b0;
    end else if (core_zero) begin
      ref_seed <= DEFAULT_SEED;
      per_cnt  <= '0;
    end else if (core_load) begin
      ref_seed <= (seed == '0) ? DEFAULT_SEED : seed;
      per_cnt  <= '0;
    end else if (q_vld) begin
      if (chk_nxt == ref_seed) begin
        if (per_inc != PERIOD) period_err <= 1'b1;
        per_cnt <= '0;
      end else if (per_cnt != '1) begin
        per_cnt <= per_inc;
      end
    end
  end
`else
  assign period_err = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl: expected burst words are queued by the
// stimulus and popped by a monitor whenever q_vld is high.
module tb_lfsr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       seed_vld;
  logic [2:0] seed;
  logic       req;
  logic [7:0] len;
  logic       abort;
  logic       ack, busy, q_vld, done, lockup_err, period_err;
  logic [2:0] q;

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  lfsr_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_vld   (seed_vld),
    .seed       (seed),
    .req        (req),
    .len        (len),
    .abort      (abort),
    .ack        (ack),
    .busy       (busy),
    .q          (q),
    .q_vld      (q_vld),
    .done       (done),
    .lockup_err (lockup_err),
    .period_err (period_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented word must match the head of the queue
  always @(negedge clk) begin
    if (q_vld === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL word: unexpected q=%b with empty queue", q);
      end else begin
        logic [2:0] w;
        w = exp_q.pop_front();
        if (q !== w) begin
          miscompares++;
          $display("FAIL word: got q=%b expected %b", q, w);
        end
      end
    end
    if (done === 1'b1) done_seen++;
  end

  task automatic push3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c);
  endtask

  task automatic load_seed(input logic [2:0] s, input logic [2:0] exp_core);
    @(posedge clk); #1 seed_vld = 1'b1; seed = s;
    @(posedge clk); #1 seed_vld = 1'b0;
    @(negedge clk);
    chk("seed_core", q, exp_core);
  endtask

  // Runs one burst; do_abort raises abort in the cycle after nwords words
  task automatic burst(input logic [7:0] l, input int nwords, input bit do_abort,
                       input logic [2:0] exp_core, input bit align, input string tag);
    bit got;
    int lat;
    int exp_lat;
    if (align) begin
      @(posedge clk); #1;
    end
    req = 1'b1; len = l;
    @(negedge clk);
    chk({tag, "_ack"}, ack, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    got = 1'b0; lat = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      req   = 1'b0;
      abort = do_abort && (c == nwords + 1);
      chk({tag, "_no_reack"}, ack, 0);
      @(negedge clk);
      if (done) begin
        got = 1'b1; lat = c;
        chk({tag, "_core_end"}, q, exp_core);
        chk({tag, "_busy_done"}, busy, 0);
      end
    end
    abort = 1'b0;
    exp_lat = do_abort ? nwords + 2 : nwords + 1;
    chk({tag, "_done_latency"}, lat, got ? exp_lat : -1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_words_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    rst_n = 1'b1; seed_vld = 1'b0; seed = '0; req = 1'b0; len = '0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_q", q, 3'b001);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_qvld", q_vld, 0);
    chk("rst_done", done, 0);
    chk("rst_lockup", lockup_err, 0);
    chk("rst_period", period_err, 0);

    // 1: len=4 from reset seed
    push3(3'b001, 3'b010, 3'b101); exp_q.push_back(3'b011);
    burst(8'd4, 4, 1'b0, 3'b111, 1'b1, "t1");

    // 2: seed and req together -> seed wins, req acked next cycle
    @(posedge clk); #1 seed_vld = 1'b1; seed = 3'b101; req = 1'b1; len = 8'd3;
    @(negedge clk);
    chk("t2_seed_blocks_ack", ack, 0);
    @(posedge clk); #1 seed_vld = 1'b0;
    push3(3'b101, 3'b011, 3'b111);
    burst(8'd3, 3, 1'b0, 3'b110, 1'b0, "t2");
    chk("t2_lockup_clear", lockup_err, 0);

    // 3: zero seed -> recovery and sticky lock-up flag
    load_seed(3'b000, 3'b001);
    chk("t3_lockup", lockup_err, 1);

    // 4: len=0 -> ack then done, no words, core unchanged
    burst(8'd0, 0, 1'b0, 3'b001, 1'b1, "t4");

    // 5: len=6 aborted after two words, then resume
    exp_q.push_back(3'b001); exp_q.push_back(3'b010);
    burst(8'd6, 2, 1'b1, 3'b101, 1'b1, "t5");
    exp_q.push_back(3'b101); exp_q.push_back(3'b011);
    burst(8'd2, 2, 1'b0, 3'b111, 1'b1, "t5b");
    chk("t5_lockup_sticky", lockup_err, 1);

    // 6: reset clears flags; 14 words wrap after 7; reset mid-burst
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_lockup", lockup_err, 0);
    chk("t6_rst_q", q, 3'b001);
    for (int r = 0; r < 2; r++) begin
      push3(3'b001, 3'b010, 3'b101);
      push3(3'b011, 3'b111, 3'b110);
      exp_q.push_back(3'b100);
    end
    burst(8'd14, 14, 1'b0, 3'b001, 1'b1, "t6");
    chk("t6_period_err", period_err, 0);

    d0 = done_seen;
    @(posedge clk); #1 req = 1'b1; len = 8'd5;
    @(negedge clk);
    chk("t6m_ack", ack, 1);
    push3(3'b001, 3'b010, 3'b101);
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t6m_busy", busy, 0);
    chk("t6m_q", q, 3'b001);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    chk("t6m_no_done", done_seen, d0);
    chk("t6m_words_left", exp_q.size(), 0);
    chk("t6m_period_err", period_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
